// File: rtl/ecb_decrypt.sv
// Per-frame XOR stream decryptor for a two-pixel-per-word video stream.
// One word in, one word out a cycle later; row and frame boundaries are flagged with the output word.
module ecb_decrypt #(
    parameter int BLOCK_SIZE = 32,
    parameter int SYNC_SIZE  = 48,
    parameter int HSIZE      = 768,
    parameter int VSIZE      = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  enable,
    input  logic [BLOCK_SIZE-1:0] key,
    input  logic                  in_valid,
    input  logic [SYNC_SIZE-1:0]  data_encrypted,
    output logic                  out_valid,
    output logic [SYNC_SIZE-1:0]  data_plain,
    output logic                  row_done,
    output logic                  frame_done,
    output logic                  drop_err
);

    localparam int COLS  = HSIZE / 2;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (VSIZE > 1) ? $clog2(VSIZE) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(VSIZE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Key repeated MSB-first across the word, truncated to the word width.
    function automatic logic [SYNC_SIZE-1:0] expand_key(input logic [BLOCK_SIZE-1:0] k);
        logic [SYNC_SIZE-1:0] r;
        r = '0;
        for (int i = 0; i < SYNC_SIZE; i++) begin
            r[SYNC_SIZE-1-i] = k[BLOCK_SIZE-1-(i % BLOCK_SIZE)];
        end
        return r;
    endfunction

    state_t               state_q, state_d;
    logic [COL_W-1:0]     col_q;
    logic [ROW_W-1:0]     row_q;
    logic [SYNC_SIZE-1:0] kexp_q;
    logic                 en_q;
    logic                 accept;
    logic                 drop;
    logic                 col_wrap;
    logic                 frame_end;

    assign col_wrap  = (col_q == COL_LAST);
    assign frame_end = col_wrap && (row_q == ROW_LAST);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        drop    = 1'b0;
        if (start) begin
            // A word arriving alongside start belongs to neither frame.
            state_d = RUN;
            drop    = in_valid;
        end else begin
            case (state_q)
                IDLE: drop = in_valid;
                RUN: begin
                    if (in_valid) begin
                        accept = 1'b1;
                        if (frame_end) state_d = DONE;
                    end
                end
                DONE: drop = in_valid;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kexp_q <= '0;
            en_q   <= 1'b0;
            col_q  <= '0;
            row_q  <= '0;
        end else if (start) begin
            kexp_q <= expand_key(key);
            en_q   <= enable;
            col_q  <= '0;
            row_q  <= '0;
        end else if (accept) begin
            if (col_wrap) begin
                col_q <= '0;
                row_q <= frame_end ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            data_plain <= '0;
            row_done   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= accept;
            row_done   <= accept && col_wrap;
            frame_done <= accept && frame_end;
            if (accept) begin
                data_plain <= en_q ? (data_encrypted ^ kexp_q) : data_encrypted;
            end
        end
    end

    // Sticky; a drop in the same cycle as start still leaves it set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_err <= 1'b0;
        end else if (drop) begin
            drop_err <= 1'b1;
        end else if (start) begin
            drop_err <= 1'b0;
        end
    end

endmodule

// File: doc/ecb_decrypt.md
ECB_DECRYPT -- requirements
Module: ecb_decrypt

Interface
REQ-001 Parameters: BLOCK_SIZE, default 32, key width in bits; SYNC_SIZE, default 48, data word width (two RGB pixels); HSIZE, default 768, pixels per row; VSIZE, default 512, rows per frame.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  one-cycle pulse: latch key and enable, clear counters, begin a frame.
REQ-005 enable  input  1  sampled with start; 1 = decrypt, 0 = bypass.
REQ-006 key  input  BLOCK_SIZE  frame key, sampled with start.
REQ-007 in_valid  input  1  data_encrypted qualifier; one word per high cycle, driven from the read-side hsync.
REQ-008 data_encrypted  input  SYNC_SIZE  cipher word {R0,G0,B0,R1,G1,B1}, R0 in MSBs.
REQ-009 out_valid  output  1  data_plain qualifier.
REQ-010 data_plain  output  SYNC_SIZE  recovered plaintext word, same byte order as input.
REQ-011 row_done  output  1  one-cycle pulse with the last output word of each row.
REQ-012 frame_done  output  1  one-cycle pulse with the last output word of the frame.
REQ-013 drop_err  output  1  sticky flag: an in_valid word was discarded.

Function
REQ-014 Key expansion: kexp = key replicated MSB-first and truncated to SYNC_SIZE MSBs (default: {key, key[31:16]}).
REQ-015 Decrypt: data_plain = data_encrypted XOR kexp_latched when enable_latched = 1; data_plain = data_encrypted when enable_latched = 0.
REQ-016 Latency: exactly 1 cycle; registered outputs; in_valid at edge N -> out_valid and data_plain at edge N+1; no stalls, full throughput.
REQ-017 out_valid low -> data_plain holds its last value.
REQ-018 FSM states: IDLE, RUN, DONE; reset state IDLE.
REQ-019 IDLE: start -> RUN; in_valid without start -> word dropped, drop_err set.
REQ-020 RUN: each accepted word increments col (0..HSIZE/2-1); col wraps to 0 and row (0..VSIZE-1) increments, row_done asserted with that output.
REQ-021 RUN: word at col = HSIZE/2-1, row = VSIZE-1 -> row_done and frame_done asserted together with its output; state -> DONE.
REQ-022 DONE: in_valid -> dropped, drop_err set; start -> RUN with counters cleared.
REQ-023 start in any state (including mid-frame RUN): counters cleared, key/enable re-latched, state -> RUN; in_valid in the same cycle is dropped and drop_err is set.
REQ-024 drop_err cleared only by rst or by start; if start and a drop coincide, the flag is set (set wins).
REQ-025 Counter widths: col ceil(log2(HSIZE/2)), row ceil(log2(VSIZE)); no other wrap is legal.

Reset
REQ-026 rst high -> immediately, without clk: state IDLE; col = 0, row = 0; kexp_latched = 0; enable_latched = 0; out_valid = 0, data_plain = 0, row_done = 0, frame_done = 0, drop_err = 0.
REQ-027 rst asserted mid-frame -> the in-flight word is lost and no out_valid follows; after release, start is required again.

Verification
REQ-028 start with key=32'hDEADBEEF, enable=1; in_valid with data_encrypted=48'hDF8EFB885706 -> next cycle out_valid=1, data_plain=48'h0123456789AB.
REQ-029 start with enable=0; data_encrypted=48'hDF8EFB885706 -> data_plain=48'hDF8EFB885706 (bypass).
REQ-030 Stream 384 words continuously -> row_done high only with the 384th output; row advances to 1.
REQ-031 Stream 196608 words -> frame_done and row_done both high with the last output; state DONE; one extra word -> no out_valid, drop_err=1.
REQ-032 in_valid before any start -> no out_valid, drop_err=1; a later start clears drop_err to 0.
REQ-033 Encrypt-then-decrypt round trip of the full kodim23 frame at the same key -> every data_plain equals the original image word.
